// File: rtl/twenty48_pkg.sv
// ----------------------------------------------------------------------------
// twenty48_pkg
//   Shared types for the 2048 game datapath. It provides the direction code
//   that travels from the button front end to the board engine, and the
//   number of directions.
//   Ports: none (package).
// ----------------------------------------------------------------------------
package twenty48_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NUM_DIRS = 4;

endpackage

// File: rtl/btn_press_detect.sv
// ----------------------------------------------------------------------------
// btn_press_detect
//   Debounces one already-synchronised button and emits exactly one
//   registered single-cycle pulse per press. A press registers on the
//   (DEBOUNCE_CYCLES+1)th consecutive high sample. The channel must then see
//   a low sample before it can fire again. Reset leaves the channel disarmed,
//   so a button held through reset has to be released before it counts.
//
//   Ports:
//     clk    in   1  system clock
//     rst    in   1  synchronous active-high reset
//     btn    in   1  raw button level
//     press  out  1  one-cycle press pulse (registered)
// ----------------------------------------------------------------------------
module btn_press_detect #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_MAX = DEBOUNCE_CYCLES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] count;
    logic             armed;

    // The counter saturates instead of wrapping, so a long hold can never
    // produce a second pulse. The pulse fires on the sample that takes the
    // count from DEBOUNCE_CYCLES to DEBOUNCE_CYCLES+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            armed <= 1'b0;
            press <= 1'b0;
        end else if (!btn) begin
            count <= '0;
            armed <= 1'b1;
            press <= 1'b0;
        end else begin
            if (count != CNT_W'(CNT_MAX)) begin
                count <= count + 1'b1;
            end
            if (armed && (count == CNT_W'(DEBOUNCE_CYCLES))) begin
                press <= 1'b1;
                armed <= 1'b0;
            end else begin
                press <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/move_input_arbiter.sv
// ----------------------------------------------------------------------------
// move_input_arbiter
//   Turns the four direction buttons into a stream of single move commands.
//   Each button has its own press detector. Presses in the same cycle are
//   resolved round-robin. Accepted moves wait in a small circular FIFO that
//   the board engine drains over a valid/ready handshake. Any discarded press,
//   whether it lost arbitration or found the FIFO full, sets a sticky flag.
//
//   Ports:
//     clk         in   1  system clock
//     rst         in   1  synchronous active-high reset
//     btn         in   4  buttons [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT
//     move_valid  out  1  FIFO holds a move
//     move_dir    out  2  head move direction code
//     move_ready  in   1  board engine takes the head move this cycle
//     dropped     out  1  sticky: some press was discarded since reset
// ----------------------------------------------------------------------------
module move_input_arbiter
    import twenty48_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int QUEUE_DEPTH     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       dropped
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [NUM_DIRS-1:0] press;
    logic [1:0]          rr_ptr;
    dir_t                winner;
    logic                win_valid;
    logic                multi_press;

    dir_t                fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                pop;
    logic                push;

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_detect
        btn_press_detect #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_detect (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .press(press[i])
        );
    end

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting at rr_ptr. The 2-bit index wraps 3->0 on
    // its own, so no explicit modulo is needed.
    always_comb begin
        winner    = DIR_UP;
        win_valid = 1'b0;
        for (int k = 0; k < NUM_DIRS; k++) begin
            if (!win_valid && press[rr_ptr + 2'(k)]) begin
                win_valid = 1'b1;
                winner    = dir_t'(rr_ptr + 2'(k));
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more
    // presses arrived together.
    assign multi_press = (press & (press - 1'b1)) != '0;

    assign move_valid = (count != '0);
    assign move_dir   = move_valid ? fifo_mem[head] : DIR_UP;
    assign full       = (count == CNT_W'(QUEUE_DEPTH));
    assign pop        = move_valid && move_ready;
    assign push       = win_valid && (!full || pop);

    // FIFO storage needs no reset. Entries are only observed through head
    // while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= winner;
        end
    end

    // The FIFO pointers, the occupancy count, the round-robin pointer and the
    // sticky drop flag. A winner is only lost when it finds the FIFO full and
    // no pop is freeing a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rr_ptr  <= 2'd0;
            dropped <= 1'b0;
        end else begin
            if (pop) begin
                head <= wrap_inc(head);
            end
            if (push) begin
                tail <= wrap_inc(tail);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (win_valid) begin
                rr_ptr <= 2'(winner) + 2'd1;
            end
            if (multi_press || (win_valid && !push)) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_move_input_arbiter.sv
// ----------------------------------------------------------------------------
// tb_move_input_arbiter
//   Directed bench for move_input_arbiter. A queue-based behavioural model
//   tracks run lengths per button, a round-robin pointer and a move queue.
//   The DUT is compared against that model on every falling edge, and
//   hand-computed expectations pin each scenario.
// ----------------------------------------------------------------------------
module tb_move_input_arbiter;

    localparam int DEB   = 4;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       dropped;

    int err_count   = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    move_input_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .QUEUE_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .move_ready(move_ready),
        .dropped   (dropped)
    );

    // Model state.
    int run     [4];
    bit armed   [4];
    bit m_press [4];
    int m_ptr;
    bit m_dropped;
    int m_q[$];
    bit m_ok = 1'b0;
    int winner;
    int n_press;

    // Directions the DUT handed over, in handover order.
    int pop_log[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual != expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic r, input int n);
        btn        = b;
        move_ready = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input logic [3:0] b);
        rst = 1'b1;
        applyStimulus(b, 1'b1, 2);
        rst = 1'b0;
        pop_log.delete();
    endtask

    // Behavioural model, advanced at each rising edge. Presses that were
    // detected last cycle are arbitrated now. Then the handshake and the
    // queue are updated, and finally this edge's button samples are examined.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                run[i]     = 0;
                armed[i]   = 1'b0;
                m_press[i] = 1'b0;
            end
            m_ptr     = 0;
            m_dropped = 1'b0;
            m_q.delete();
            m_ok      = 1'b1;
        end else begin
            winner  = -1;
            n_press = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_press[(m_ptr + k) % 4]) begin
                    n_press++;
                    if (winner < 0) winner = (m_ptr + k) % 4;
                end
            end
            if (n_press > 1) m_dropped = 1'b1;
            if (m_q.size() > 0 && move_ready) void'(m_q.pop_front());
            if (winner >= 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(winner);
                else m_dropped = 1'b1;
                m_ptr = (winner + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                if (btn[i]) begin
                    run[i]++;
                    m_press[i] = armed[i] && (run[i] == DEB + 1);
                    if (m_press[i]) armed[i] = 1'b0;
                end else begin
                    run[i]     = 0;
                    armed[i]   = 1'b1;
                    m_press[i] = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, and logging of handovers.
    always @(negedge clk) begin
        if (m_ok) begin
            checkOutput("move_valid", int'(move_valid), (m_q.size() > 0) ? 1 : 0);
            if (m_q.size() > 0) checkOutput("move_dir", int'(move_dir), m_q[0]);
            checkOutput("dropped", int'(dropped), int'(m_dropped));
            if (!rst && move_valid && move_ready) pop_log.push_back(int'(move_dir));
        end
    end

    initial begin
        rst        = 1'b1;
        btn        = 4'b0000;
        move_ready = 1'b0;

        // 1: single LEFT press, 5 samples long
        doReset(4'b0000);
        checkOutput("reset_valid", int'(move_valid), 0);
        checkOutput("reset_dir", int'(move_dir), 0);
        checkOutput("reset_dropped", int'(dropped), 0);
        applyStimulus(4'b0000, 1'b1, 3);
        applyStimulus(4'b0100, 1'b1, 5);
        checkOutput("t1_not_yet_valid", int'(move_valid), 0);
        applyStimulus(4'b0000, 1'b1, 1);
        checkOutput("t1_valid", int'(move_valid), 1);
        checkOutput("t1_dir", int'(move_dir), 2);
        applyStimulus(4'b0000, 1'b1, 4);
        checkOutput("t1_idle", int'(move_valid), 0);
        checkOutput("t1_pop_count", pop_log.size(), 1);
        checkOutput("t1_pop_dir", (pop_log.size() > 0) ? pop_log[0] : -1, 2);

        // 2: bounce then long hold of UP
        pop_log.delete();
        applyStimulus(4'b0001, 1'b1, 3);
        applyStimulus(4'b0000, 1'b1, 1);
        applyStimulus(4'b0001, 1'b1, 4);
        checkOutput("t2_after4", int'(move_valid), 0);
        applyStimulus(4'b0001, 1'b1, 1);
        checkOutput("t2_after5", int'(move_valid), 0);
        applyStimulus(4'b0001, 1'b1, 1);
        checkOutput("t2_valid", int'(move_valid), 1);
        checkOutput("t2_dir", int'(move_dir), 0);
        applyStimulus(4'b0001, 1'b1, 2);
        applyStimulus(4'b0000, 1'b1, 3);
        checkOutput("t2_pop_count", pop_log.size(), 1);

        // 3: UP and RIGHT together, twice
        doReset(4'b0000);
        applyStimulus(4'b0000, 1'b1, 2);
        applyStimulus(4'b1001, 1'b1, 6);
        checkOutput("t3_dropped", int'(dropped), 1);
        checkOutput("t3_first_dir", int'(move_dir), 0);
        applyStimulus(4'b0000, 1'b1, 2);
        applyStimulus(4'b1001, 1'b1, 6);
        checkOutput("t3_second_dir", int'(move_dir), 3);
        applyStimulus(4'b0000, 1'b1, 3);
        checkOutput("t3_pop_count", pop_log.size(), 2);
        checkOutput("t3_pop1", (pop_log.size() > 1) ? pop_log[1] : -1, 3);

        // 4: overflow with ready low
        doReset(4'b0000);
        applyStimulus(4'b0000, 1'b0, 2);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0101, 1'b0, 1);
        applyStimulus(4'b0111, 1'b0, 8);
        checkOutput("t4_dropped", int'(dropped), 1);
        checkOutput("t4_head", int'(move_dir), 0);
        applyStimulus(4'b0000, 1'b1, 4);
        checkOutput("t4_empty", int'(move_valid), 0);
        checkOutput("t4_pop_count", pop_log.size(), 2);
        checkOutput("t4_pop0", (pop_log.size() > 0) ? pop_log[0] : -1, 0);
        checkOutput("t4_pop1", (pop_log.size() > 1) ? pop_log[1] : -1, 2);

        // 5: push and pop in the same cycle while full
        doReset(4'b0000);
        applyStimulus(4'b0000, 1'b0, 2);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0101, 1'b0, 7);
        checkOutput("t5_full_head", int'(move_dir), 0);
        applyStimulus(4'b0111, 1'b0, 5);
        applyStimulus(4'b0111, 1'b1, 1);
        checkOutput("t5_no_drop", int'(dropped), 0);
        checkOutput("t5_head", int'(move_dir), 2);
        applyStimulus(4'b0111, 1'b0, 1);
        checkOutput("t5_stable", int'(move_dir), 2);
        applyStimulus(4'b0000, 1'b1, 4);
        checkOutput("t5_pop_count", pop_log.size(), 3);
        checkOutput("t5_pop2", (pop_log.size() > 2) ? pop_log[2] : -1, 1);
        checkOutput("t5_empty", int'(move_valid), 0);

        // 6: DOWN held through reset
        applyStimulus(4'b0010, 1'b1, 10);
        doReset(4'b0010);
        applyStimulus(4'b0010, 1'b1, 50);
        checkOutput("t6_no_move", pop_log.size(), 0);
        applyStimulus(4'b0000, 1'b1, 1);
        applyStimulus(4'b0010, 1'b1, 5);
        applyStimulus(4'b0000, 1'b1, 3);
        checkOutput("t6_pop_count", pop_log.size(), 1);
        checkOutput("t6_pop_dir", (pop_log.size() > 0) ? pop_log[0] : -1, 1);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
